// File: rtl/dds_pkg.sv
// Shared defaults, FSM state type and input-format helper for the DDS tone meter.
package dds_pkg;

    localparam int DW_DEF = 12;
    localparam int PW_DEF = 16;
    localparam int CW_DEF = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Offset binary to two's complement: flip the MSB of a w-bit value.
    function automatic logic [31:0] to_signed(input logic [31:0] x, input int w);
        return x ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/dds_zc_detect.sv
// Input format conversion, hysteresis arming and rising zero-crossing strobe for the sin channel.
module dds_zc_detect
    import dds_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int OFFSET_BIN = 0,
    parameter int HYST       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [DW-1:0] sin,
    input  logic [DW-1:0] cos,
    output logic [DW-1:0] sin_s,
    output logic [DW-1:0] cos_s,
    output logic          xing
);

    localparam int NEG_HYST = -HYST;

    logic signed [DW-1:0] sin_c;
    logic signed [DW-1:0] cos_c;
    logic signed [31:0]   sin_w;
    logic                 below;
    logic                 armed;

    always_comb begin
        sin_c = sin;
        cos_c = cos;
        if (OFFSET_BIN != 0) begin
            sin_c = DW'(to_signed(32'(sin), DW));
            cos_c = DW'(to_signed(32'(cos), DW));
        end
    end

    assign sin_w = 32'(sin_c);
    assign below = (sin_w < NEG_HYST);

    // A crossing needs a prior excursion below -HYST, so noise around zero cannot retrigger.
    assign xing  = in_vld && armed && !sin_c[DW-1];
    assign sin_s = sin_c;
    assign cos_s = cos_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (clr || xing) begin
            armed <= 1'b0;
        end else if (in_vld && below) begin
            armed <= 1'b1;
        end
    end

endmodule

// File: rtl/dds_tone_meter.sv
// Measures period (samples and clocks), peak-to-peak amplitude and rotation direction
// of a DDS sin/cos stream between consecutive rising crossings of sin.
module dds_tone_meter
    import dds_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int OFFSET_BIN = 0,
    parameter int HYST       = 16,
    parameter int PW         = PW_DEF,
    parameter int CW         = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [DW-1:0] sin,
    input  logic [DW-1:0] cos,
    output logic          meas_vld,
    output logic [PW-1:0] period_smp,
    output logic [CW-1:0] period_clk,
    output logic [DW:0]   amp_pp,
    output logic          dir,
    output logic          locked,
    output logic          timeout
);

    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SNEG = -SMAX;

    state_t               state;
    state_t               state_nxt;
    logic signed [DW-1:0] sin_s;
    logic signed [DW-1:0] cos_s;
    logic                 xing;
    logic                 sat;
    logic [PW-1:0]        smp_cnt;
    logic [CW-1:0]        clk_cnt;
    logic signed [DW-1:0] mn;
    logic signed [DW-1:0] mx;
    logic signed [DW-1:0] nmn;
    logic signed [DW-1:0] nmx;
    logic signed [DW:0]   amp_new;

    dds_zc_detect #(
        .DW         (DW),
        .OFFSET_BIN (OFFSET_BIN),
        .HYST       (HYST)
    ) u_zc (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .in_vld (in_vld),
        .sin    (sin),
        .cos    (cos),
        .sin_s  (sin_s),
        .cos_s  (cos_s),
        .xing   (xing)
    );

    assign sat     = (smp_cnt == '1) || (clk_cnt == '1);
    assign nmx     = (sin_s > mx) ? sin_s : mx;
    assign nmn     = (sin_s < mn) ? sin_s : mn;
    assign amp_new = {nmx[DW-1], nmx} - {nmn[DW-1], nmn};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xing) state_nxt = RUN;
            RUN:     if (sat)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_vld   <= 1'b0;
            period_smp <= '0;
            period_clk <= '0;
            amp_pp     <= '0;
            dir        <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            smp_cnt    <= '0;
            clk_cnt    <= '0;
            mn         <= SMAX;
            mx         <= SNEG;
        end else if (clr) begin
            meas_vld   <= 1'b0;
            period_smp <= '0;
            period_clk <= '0;
            amp_pp     <= '0;
            dir        <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            smp_cnt    <= '0;
            clk_cnt    <= '0;
            mn         <= SMAX;
            mx         <= SNEG;
        end else begin
            meas_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (xing) begin
                        smp_cnt <= PW'(1);
                        clk_cnt <= CW'(1);
                        mn      <= sin_s;
                        mx      <= sin_s;
                    end
                end
                RUN: begin
                    // Saturation abandons the period; last published measurement is kept.
                    if (sat) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        smp_cnt <= '0;
                        clk_cnt <= '0;
                        mn      <= SMAX;
                        mx      <= SNEG;
                    end else if (xing) begin
                        period_smp <= smp_cnt;
                        period_clk <= clk_cnt;
                        amp_pp     <= amp_new;
                        dir        <= !cos_s[DW-1] && (cos_s != '0);
                        meas_vld   <= 1'b1;
                        locked     <= 1'b1;
                        smp_cnt    <= PW'(1);
                        clk_cnt    <= CW'(1);
                        mn         <= sin_s;
                        mx         <= sin_s;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                        if (in_vld) begin
                            smp_cnt <= smp_cnt + PW'(1);
                            mn      <= nmn;
                            mx      <= nmx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_tone_meter.sv
// Scoreboard bench for dds_tone_meter: directed tone segments push expected measurements,
// a negedge monitor pops and compares them whenever meas_vld is seen.
module tb_dds_tone_meter;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_vld;
    logic [11:0] sin_d;
    logic [11:0] cos_d;
    logic        meas_vld;
    logic [15:0] period_smp;
    logic [23:0] period_clk;
    logic [12:0] amp_pp;
    logic        dir;
    logic        locked;
    logic        timeout;

    typedef struct {
        int psmp;
        int pclk;
        int amp;
        int dir;
        int tol_p;
        int tol_a;
        bit chk;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    dds_tone_meter dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_vld     (in_vld),
        .sin        (sin_d),
        .cos        (cos_d),
        .meas_vld   (meas_vld),
        .period_smp (period_smp),
        .period_clk (period_clk),
        .amp_pp     (amp_pp),
        .dir        (dir),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp, input int tol);
        int d;
        n_tests++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    always @(negedge clk) begin
        if (meas_vld) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_meas: got meas_vld with period_smp=%0d, expected none at %0t",
                         period_smp, $time);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.chk) begin
                    check("period_smp", int'(period_smp), mon_e.psmp, mon_e.tol_p);
                    check("period_clk", int'(period_clk), mon_e.pclk, mon_e.tol_p);
                    check("amp_pp", int'(amp_pp), mon_e.amp, mon_e.tol_a);
                    check("dir", int'(dir), mon_e.dir, 0);
                    check("locked", int'(locked), 1, 0);
                end
            end
        end
    end

    task automatic send(input int s, input int c, input bit v);
        @(negedge clk);
        in_vld = v;
        sin_d  = 12'(s);
        cos_d  = 12'(c);
    endtask

    // One tone segment, samples n0..n1 of period p, one valid every sp clocks.
    // Crossings at multiples of p within [mf, ml] are expected to produce a measurement;
    // the one at mdc is expected but its values are not checked.
    task automatic tone(input int p, input int sp, input int a, input int csg, input bit noisy,
                        input int n0, input int n1, input int mf, input int ml, input int mdc,
                        input exp_t ex);
        real  ph;
        int   s;
        int   c;
        exp_t t;
        for (int n = n0; n <= n1; n++) begin
            ph = 2.0 * PI * $itor(n) / $itor(p);
            s  = rnd($itor(a) * $sin(ph)) + (noisy ? ((n * 7) % 21) - 10 : 0);
            c  = csg * rnd($itor(a) * $cos(ph));
            if (((n + 2) % p == 0) && (n + 2 >= mf) && (n + 2 <= ml)) begin
                t     = ex;
                t.chk = (n + 2 != mdc);
                sbq.push_back(t);
            end
            send(s, c, 1'b1);
            for (int k = 1; k < sp; k++) send(s, c, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        in_vld = 1'b0;
        clr    = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_meas_vld"}, int'(meas_vld), 0, 0);
        check({tag, "_period_smp"}, int'(period_smp), 0, 0);
        check({tag, "_period_clk"}, int'(period_clk), 0, 0);
        check({tag, "_amp_pp"}, int'(amp_pp), 0, 0);
        check({tag, "_dir"}, int'(dir), 0, 0);
        check({tag, "_locked"}, int'(locked), 0, 0);
        check({tag, "_timeout"}, int'(timeout), 0, 0);
    endtask

    initial begin
        exp_t ex;
        rst    = 1'b1;
        clr    = 1'b0;
        in_vld = 1'b0;
        sin_d  = '0;
        cos_d  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Full-scale tone, 720 samples per period, valid every second clock.
        ex = '{psmp: 720, pclk: 1440, amp: 4094, dir: 1, tol_p: 0, tol_a: 0, chk: 1'b1};
        tone(720, 2, 2047, 1, 1'b0, 0, 1740, 1440, 1440, -1, ex);
        check("locked_after_tone", int'(locked), 1, 0);
        check("timeout_after_tone", int'(timeout), 0, 0);

        // Frequency switch mid-period: first measurement is mixed, then 180/180.
        ex = '{psmp: 180, pclk: 180, amp: 4094, dir: 1, tol_p: 0, tol_a: 0, chk: 1'b1};
        tone(180, 1, 2047, 1, 1'b0, 1, 540, 180, 540, 180, ex);

        // Same tone with cos negated: reverse rotation.
        ex = '{psmp: 180, pclk: 180, amp: 4094, dir: 0, tol_p: 0, tol_a: 0, chk: 1'b1};
        tone(180, 1, 2047, -1, 1'b0, 1, 360, 180, 360, -1, ex);

        // Small noisy tone: exactly one measurement per period.
        pulse_clr();
        check("clr_locked", int'(locked), 0, 0);
        ex = '{psmp: 100, pclk: 100, amp: 208, dir: 1, tol_p: 4, tol_a: 12, chk: 1'b1};
        tone(100, 1, 100, 1, 1'b1, 1, 420, 200, 400, -1, ex);

        // Constant negative input while running: sample counter saturates.
        for (int i = 0; i < 60000; i++) send(-500, 0, 1'b1);
        check("pre_sat_timeout", int'(timeout), 0, 0);
        check("pre_sat_locked", int'(locked), 1, 0);
        for (int i = 0; i < 6000; i++) send(-500, 0, 1'b1);
        check("sat_timeout", int'(timeout), 1, 0);
        check("sat_locked", int'(locked), 0, 0);
        pulse_clr();
        check_zero("post_clr");

        // Tone resumes after clr, then an asynchronous reset mid-period.
        ex = '{psmp: 180, pclk: 180, amp: 4094, dir: 1, tol_p: 0, tol_a: 0, chk: 1'b1};
        tone(180, 1, 2047, 1, 1'b0, 1, 450, 360, 360, -1, ex);
        check("resume_locked", int'(locked), 1, 0);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        #13 rst = 1'b0;
        tone(180, 1, 2047, 1, 1'b0, 451, 720, 720, 720, -1, ex);

        repeat (5) send(0, 0, 1'b0);
        check("scoreboard_drained", sbq.size(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
